// File: rtl/game_mode_if.sv
// ---------------------------------------------------------------------------
// game_mode_if
//   Bundles the game sequencer's pulse inputs, character/camera inputs and
//   mode/time/Y outputs so they travel as one port.
//   Parameters:
//     PW  : unsigned physics/time width
//     SPW : signed coordinate width
//     CW  : camera level width
//   Modports:
//     slave  : used by game_mode_ctrl (pulses/levels in, mode/time/Y out)
//     master : used by whatever drives the sequencer (the opposite view)
// ---------------------------------------------------------------------------
interface game_mode_if #(
  parameter int PW  = 16,
  parameter int SPW = 17,
  parameter int CW  = 6
);
  logic                  char_tick;
  logic                  start_pulse;
  logic                  pause_pulse;
  logic                  up_pulse;
  logic                  down_pulse;
  logic                  dbg_sw;
  logic                  goal_reached;
  logic signed [SPW-1:0] char_pos_y;
  logic        [CW-1:0]  camera_y;

  logic        [1:0]     mode;
  logic                  char_tick_en;
  logic                  char_rst_req;
  logic        [PW-1:0]  game_time;
  logic signed [SPW-1:0] abs_char_y;

  modport slave (
    input  char_tick, start_pulse, pause_pulse, up_pulse, down_pulse,
           dbg_sw, goal_reached, char_pos_y, camera_y,
    output mode, char_tick_en, char_rst_req, game_time, abs_char_y
  );

  modport master (
    output char_tick, start_pulse, pause_pulse, up_pulse, down_pulse,
           dbg_sw, goal_reached, char_pos_y, camera_y,
    input  mode, char_tick_en, char_rst_req, game_time, abs_char_y
  );
endinterface

// File: rtl/game_mode_ctrl.sv
// ---------------------------------------------------------------------------
// game_mode_ctrl
//   Top-level game sequencer. Runs the TITLE/PLAY/PAUSE/WIN mode FSM, gates
//   the character-physics tick so physics only advances in PLAY, counts
//   play time (saturating), issues a one-cycle character reset on game
//   start, and registers the Y coordinate that drives block_gen.
//
//   Optional feature (macro DEBUG_SCROLL_EN):
//     While paused with dbg_sw set, a debug camera Y stepped by up/down
//     pulses replaces the live character Y fed to block_gen. Without the
//     macro the debug path does not exist and up/down/dbg_sw/camera_y are
//     unused.
//
//   Ports:
//     sys_clk   : system clock
//     sys_rst_n : asynchronous active-low reset
//     gif       : game_mode_if.slave
//                 in : char_tick, start_pulse, pause_pulse, up_pulse,
//                      down_pulse, dbg_sw, goal_reached, char_pos_y, camera_y
//                 out: mode (registered), char_tick_en (combinational),
//                      char_rst_req (registered pulse), game_time,
//                      abs_char_y (registered)
// ---------------------------------------------------------------------------
module game_mode_ctrl #(
  parameter int PHY_WIDTH        = 16,
  parameter int SIGNED_PHY_WIDTH = PHY_WIDTH + 1,
  parameter int CAMERA_WIDTH     = 6,
  parameter int BLOCK_WIDTH      = 480,
  parameter int DEBUG_Y_INIT     = 10
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  game_mode_if.slave   gif
);

  localparam int PW  = PHY_WIDTH;
  localparam int SPW = SIGNED_PHY_WIDTH;

  localparam logic signed [SPW-1:0] Y_INIT = SPW'(DEBUG_Y_INIT);

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    WIN   = 2'd3
  } mode_e;

  mode_e                 state;
  mode_e                 state_nxt;
  logic                  tick_en;
  logic                  start_game;
  logic                  enter_pause;
  logic                  char_rst_req_q;
  logic        [PW-1:0]  game_time_q;
  logic signed [SPW-1:0] abs_char_y_q;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= TITLE;
    else            state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of
  // inferred latches when no branch fires.
  always_comb begin
    state_nxt = state;
    unique case (state)
      TITLE: if (gif.start_pulse) state_nxt = PLAY;
      // Reaching the goal on a physics tick beats a simultaneous pause.
      PLAY: begin
        if (gif.goal_reached && gif.char_tick) state_nxt = WIN;
        else if (gif.pause_pulse)              state_nxt = PAUSE;
      end
      PAUSE: if (gif.pause_pulse) state_nxt = PLAY;
      WIN:   if (gif.start_pulse) state_nxt = TITLE;
      default: state_nxt = TITLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and transition strobes
  // -------------------------------------------------------------------------
  always_comb begin
    tick_en          = gif.char_tick && (state == PLAY);
    start_game       = (state == TITLE) && gif.start_pulse;
    enter_pause      = (state == PLAY)  && (state_nxt == PAUSE);
    gif.mode         = state;
    gif.char_tick_en = tick_en;
    gif.char_rst_req = char_rst_req_q;
    gif.game_time    = game_time_q;
    gif.abs_char_y   = abs_char_y_q;
  end

  // Character reset request: one cycle after the TITLE->PLAY decision.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) char_rst_req_q <= 1'b0;
    else            char_rst_req_q <= start_game;
  end

  // Play-time counter: cleared on game start, saturates instead of wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      game_time_q <= '0;
    end else if (start_game) begin
      game_time_q <= '0;
    end else if (tick_en && (game_time_q != '1)) begin
      game_time_q <= game_time_q + PW'(1);
    end
  end

`ifdef DEBUG_SCROLL_EN
  localparam logic        [CAMERA_WIDTH-1:0] MAX_CAM = '1;
  localparam logic signed [SPW-1:0]          Y_STEP  = SPW'(BLOCK_WIDTH);

  logic                  dbg_active;
  logic signed [SPW-1:0] debug_y;

  assign dbg_active = (state == PAUSE) && gif.dbg_sw;

  // Debug camera Y. Restarts from the base value every time the game is
  // paused; up stops at the top camera level, down at camera level 0 snaps
  // back to the base value. Opposing presses in one cycle cancel.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      debug_y <= Y_INIT;
    end else if (enter_pause) begin
      debug_y <= Y_INIT;
    end else if (dbg_active) begin
      if (gif.up_pulse && !gif.down_pulse) begin
        if (gif.camera_y < MAX_CAM) debug_y <= debug_y + Y_STEP;
      end else if (gif.down_pulse && !gif.up_pulse) begin
        debug_y <= (gif.camera_y == '0) ? Y_INIT : debug_y - Y_STEP;
      end
    end
  end
`else
  logic dbg_unused;
  assign dbg_unused = &{1'b0, gif.up_pulse, gif.down_pulse, gif.dbg_sw,
                        gif.camera_y, BLOCK_WIDTH[0]};
`endif

  // Y fed to block_gen, registered one cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      abs_char_y_q <= Y_INIT;
    end else begin
`ifdef DEBUG_SCROLL_EN
      abs_char_y_q <= dbg_active ? debug_y : gif.char_pos_y;
`else
      abs_char_y_q <= gif.char_pos_y;
`endif
    end
  end

endmodule
